// File: rtl/instruction_fetcher_if.sv
// Program-memory read channel between the instruction fetcher (master) and the
// program-memory controller (slave): valid/address request, ready/data response.
interface instruction_fetcher_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16
) ();
    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;

    modport master (
        output mem_read_valid,
        output mem_read_address,
        input  mem_read_ready,
        input  mem_read_data
    );

    modport slave (
        input  mem_read_valid,
        input  mem_read_address,
        output mem_read_ready,
        output mem_read_data
    );
endinterface

// File: rtl/instruction_fetcher.sv
// Per-core instruction fetch stage with a direct-mapped, one-instruction-per-line
// cache in front of the program-memory read channel. Hit/miss counters saturate.
module instruction_fetcher #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int CACHE_LINES           = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             flush,
    instruction_fetcher_if.master            mem,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic [15:0]                      hit_count,
    output logic [15:0]                      miss_count
);
    localparam int IDX_BITS = $clog2(CACHE_LINES);
    localparam int TAG_BITS = PROGRAM_MEM_ADDR_BITS - IDX_BITS;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'd0,
        CORE_FETCH   = 3'd1,
        CORE_DECODE  = 3'd2,
        CORE_REQUEST = 3'd3,
        CORE_WAIT    = 3'd4,
        CORE_EXECUTE = 3'd5,
        CORE_UPDATE  = 3'd6,
        CORE_DONE    = 3'd7
    } core_state_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCHING = 3'd1,
        S_FETCHED  = 3'd2
    } fetch_state_t;

    fetch_state_t state;

    logic [CACHE_LINES-1:0]           line_valid;
    logic [TAG_BITS-1:0]              tag_mem  [CACHE_LINES];
    logic [PROGRAM_MEM_DATA_BITS-1:0] data_mem [CACHE_LINES];

    logic [IDX_BITS-1:0] lookup_idx;
    logic [TAG_BITS-1:0] lookup_tag;
    logic [IDX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0] fill_tag;
    logic                lookup_hit;
    logic                fill_en;

    assign lookup_idx = current_pc[IDX_BITS-1:0];
    assign lookup_tag = current_pc[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];
    assign lookup_hit = line_valid[lookup_idx] && (tag_mem[lookup_idx] == lookup_tag);

    // The fill uses the registered request address, not current_pc.
    assign fill_idx = mem.mem_read_address[IDX_BITS-1:0];
    assign fill_tag = mem.mem_read_address[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];
    assign fill_en  = !reset && (state == S_FETCHING) && mem.mem_read_ready && !flush;

    assign fetcher_state = state;

    // NOTE: tag/data storage has no reset; the valid bits alone decide whether
    // an entry is usable, which keeps the arrays mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= mem.mem_read_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= S_IDLE;
            line_valid           <= '0;
            mem.mem_read_valid   <= 1'b0;
            mem.mem_read_address <= '0;
            instruction          <= '0;
            hit_count            <= '0;
            miss_count           <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (core_state == CORE_FETCH) begin
                        if (lookup_hit) begin
                            instruction <= data_mem[lookup_idx];
                            state       <= S_FETCHED;
                            if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
                        end else begin
                            mem.mem_read_valid   <= 1'b1;
                            mem.mem_read_address <= current_pc;
                            state                <= S_FETCHING;
                            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
                        end
                    end
                end
                S_FETCHING: begin
                    if (mem.mem_read_ready) begin
                        instruction        <= mem.mem_read_data;
                        mem.mem_read_valid <= 1'b0;
                        state              <= S_FETCHED;
                        if (!flush) line_valid[fill_idx] <= 1'b1;
                    end
                end
                S_FETCHED: begin
                    if (core_state == CORE_DECODE) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // Flush wins over a same-edge fill; a same-edge lookup already used old contents.
            if (flush) line_valid <= '0;
        end
    end
endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher: stimulus pushes expected instructions
// into a scoreboard queue, a negedge monitor pops one on every entry to FETCHED.
module tb_instruction_fetcher;
    localparam int A = 8;
    localparam int D = 16;

    localparam logic [2:0] C_IDLE    = 3'd0;
    localparam logic [2:0] C_FETCH   = 3'd1;
    localparam logic [2:0] C_DECODE  = 3'd2;
    localparam logic [2:0] C_EXECUTE = 3'd5;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   core_state;
    logic [A-1:0] current_pc;
    logic         flush;
    logic [2:0]   fetcher_state;
    logic [D-1:0] instruction;
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;

    instruction_fetcher_if #(.ADDR_BITS(A), .DATA_BITS(D)) mem_if ();

    instruction_fetcher #(
        .PROGRAM_MEM_ADDR_BITS(A),
        .PROGRAM_MEM_DATA_BITS(D),
        .CACHE_LINES(8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .core_state   (core_state),
        .current_pc   (current_pc),
        .flush        (flush),
        .mem          (mem_if.master),
        .fetcher_state(fetcher_state),
        .instruction  (instruction),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_hits;
    logic [15:0] exp_misses;
    logic [2:0]  prev_state = 3'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Scoreboard monitor: one expected instruction per entry into FETCHED.
    always @(negedge clk) begin
        if (!reset && fetcher_state == 3'd2 && prev_state != 3'd2) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_fetched: got instruction %0h with nothing expected", instruction);
            end else begin
                check("instruction", {16'h0, instruction}, {16'h0, exp_q.pop_front()});
            end
        end
        prev_state = fetcher_state;
    end

    // lat==0 expects a hit; otherwise memory answers on the lat-th valid cycle.
    task automatic fetch(input logic [A-1:0] pc, input logic [D-1:0] data, input int lat,
                         input bit flush_lookup, input bit flush_ready, input int hold);
        exp_q.push_back(data);
        @(negedge clk);
        core_state = C_FETCH;
        current_pc = pc;
        flush      = flush_lookup;
        @(negedge clk);
        flush = 1'b0;
        if (lat == 0) begin
            exp_hits = sat_inc(exp_hits);
            check("hit_state", {29'h0, fetcher_state}, 32'd2);
            check("hit_no_mem", {31'h0, mem_if.mem_read_valid}, 32'd0);
        end else begin
            exp_misses = sat_inc(exp_misses);
            for (int i = 0; i < lat; i++) begin
                check("miss_state", {29'h0, fetcher_state}, 32'd1);
                check("miss_valid", {31'h0, mem_if.mem_read_valid}, 32'd1);
                check("miss_addr", {24'h0, mem_if.mem_read_address}, {24'h0, pc});
                if (i == lat - 1) begin
                    mem_if.mem_read_ready = 1'b1;
                    mem_if.mem_read_data  = data;
                    flush                 = flush_ready;
                end
                @(negedge clk);
                mem_if.mem_read_ready = 1'b0;
                mem_if.mem_read_data  = 16'h0;
                flush                 = 1'b0;
            end
            check("fill_state", {29'h0, fetcher_state}, 32'd2);
            check("fill_valid_drop", {31'h0, mem_if.mem_read_valid}, 32'd0);
        end
        check("hit_count", {16'h0, hit_count}, {16'h0, exp_hits});
        check("miss_count", {16'h0, miss_count}, {16'h0, exp_misses});
        core_state = C_EXECUTE;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("fetched_hold", {29'h0, fetcher_state}, 32'd2);
            check("instr_hold", {16'h0, instruction}, {16'h0, data});
        end
        core_state = C_DECODE;
        @(negedge clk);
        check("back_to_idle", {29'h0, fetcher_state}, 32'd0);
        core_state = C_IDLE;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        reset                 = 1'b1;
        core_state            = C_IDLE;
        current_pc            = '0;
        flush                 = 1'b0;
        mem_if.mem_read_ready = 1'b0;
        mem_if.mem_read_data  = '0;
        exp_hits              = '0;
        exp_misses            = '0;
        repeat (3) @(negedge clk);
        check("rst_state", {29'h0, fetcher_state}, 32'd0);
        check("rst_valid", {31'h0, mem_if.mem_read_valid}, 32'd0);
        check("rst_addr", {24'h0, mem_if.mem_read_address}, 32'd0);
        check("rst_instr", {16'h0, instruction}, 32'd0);
        check("rst_hits", {16'h0, hit_count}, 32'd0);
        check("rst_misses", {16'h0, miss_count}, 32'd0);
        reset = 1'b0;

        // Cold miss then hit on PC 0x00.
        fetch(8'h00, 16'h1234, 3, 0, 0, 0);
        fetch(8'h00, 16'h1234, 0, 0, 0, 2);

        // Conflicting PCs 0x03 / 0x0B share index 3 and evict each other.
        fetch(8'h03, 16'hA003, 1, 0, 0, 0);
        fetch(8'h0B, 16'hB00B, 2, 0, 0, 0);
        fetch(8'h03, 16'hC003, 1, 0, 0, 0);
        fetch(8'h03, 16'hC003, 0, 0, 0, 0);

        // Fill 0x05, flush while idle, refetch misses.
        fetch(8'h05, 16'h5555, 2, 0, 0, 0);
        fetch(8'h05, 16'h5555, 0, 0, 0, 0);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        fetch(8'h05, 16'h5A5A, 1, 0, 0, 0);
        fetch(8'h00, 16'h0F0F, 1, 0, 0, 0);

        // Flush on the ready edge: data delivered, line not installed.
        fetch(8'h07, 16'h7777, 2, 0, 1, 0);
        fetch(8'h07, 16'h7878, 1, 0, 0, 0);
        fetch(8'h07, 16'h7878, 0, 0, 0, 0);

        // Flush on the lookup edge: lookup still sees old contents.
        fetch(8'h10, 16'h1010, 1, 0, 0, 0);
        fetch(8'h10, 16'h1010, 0, 1, 0, 0);
        fetch(8'h10, 16'h2020, 1, 0, 0, 0);

        // Ready while idle is ignored.
        @(negedge clk);
        mem_if.mem_read_ready = 1'b1;
        mem_if.mem_read_data  = 16'hBEEF;
        @(negedge clk);
        mem_if.mem_read_ready = 1'b0;
        check("idle_ready_state", {29'h0, fetcher_state}, 32'd0);
        check("idle_ready_instr", {16'h0, instruction}, 32'h2020);

        // Reset in the middle of a memory request.
        @(negedge clk);
        core_state = C_FETCH;
        current_pc = 8'h20;
        @(negedge clk);
        check("pre_rst_valid", {31'h0, mem_if.mem_read_valid}, 32'd1);
        reset      = 1'b1;
        core_state = C_IDLE;
        @(negedge clk);
        reset = 1'b0;
        exp_hits   = '0;
        exp_misses = '0;
        check("midrst_state", {29'h0, fetcher_state}, 32'd0);
        check("midrst_valid", {31'h0, mem_if.mem_read_valid}, 32'd0);
        check("midrst_hits", {16'h0, hit_count}, 32'd0);
        check("midrst_misses", {16'h0, miss_count}, 32'd0);
        mem_if.mem_read_ready = 1'b1;
        mem_if.mem_read_data  = 16'hDEAD;
        @(negedge clk);
        mem_if.mem_read_ready = 1'b0;
        check("late_ready_state", {29'h0, fetcher_state}, 32'd0);
        check("late_ready_instr", {16'h0, instruction}, 32'd0);

        // Reset cleared the cache: 0x00 misses again, then hits.
        fetch(8'h00, 16'h4321, 1, 0, 0, 0);
        fetch(8'h00, 16'h4321, 0, 0, 0, 0);

        // Saturation: preload the hit counter near its ceiling.
        @(negedge clk);
        force dut.hit_count = 16'hFFFE;
        #1;
        release dut.hit_count;
        exp_hits = 16'hFFFE;
        fetch(8'h00, 16'h4321, 0, 0, 0, 0);
        fetch(8'h00, 16'h4321, 0, 0, 0, 0);
        fetch(8'h00, 16'h4321, 0, 0, 0, 0);
        check("sat_hits", {16'h0, hit_count}, 32'hFFFF);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
